// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR request arbiter states, owner encoding and register struct
package csr_pkg;

    import river_cfg_pkg::*;

    typedef enum logic [1:0] {
        ArbState_Idle = 2'd0,
        ArbState_Req  = 2'd1,
        ArbState_Resp = 2'd2,
        ArbState_Out  = 2'd3
    } arb_state_t;

    // Owner_D is the complement of Owner_E so round-robin is a bit inversion
    localparam logic Owner_E = 1'b0;
    localparam logic Owner_D = 1'b1;

    typedef struct packed {
        arb_state_t                  state;
        logic                        owner;
        logic                        last_grant;
        logic                        drain;
        logic [CsrReq_TotalBits-1:0] req_type;
        logic [11:0]                 req_addr;
        logic [RISCV_ARCH-1:0]       req_data;
        logic [RISCV_ARCH-1:0]       resp_data;
        logic                        resp_exception;
    } csr_req_arbiter_registers;

    localparam csr_req_arbiter_registers csr_req_arbiter_r_reset = '{
        state:          ArbState_Idle,
        owner:          Owner_E,
        last_grant:     Owner_D,
        drain:          1'b0,
        req_type:       '0,
        req_addr:       '0,
        req_data:       '0,
        resp_data:      '0,
        resp_exception: 1'b0
    };

endpackage

// File: rtl/river_cfg_pkg.sv
// rtl/river_cfg_pkg.sv - core-wide widths and CSR request type encoding
package river_cfg_pkg;

    localparam int RISCV_ARCH = 64;

    // One-hot CSR request type bit positions
    localparam int CsrReq_ReadBit       = 0;
    localparam int CsrReq_WriteBit      = 1;
    localparam int CsrReq_TrapReturnBit = 2;
    localparam int CsrReq_ExceptionBit  = 3;
    localparam int CsrReq_InterruptBit  = 4;
    localparam int CsrReq_BreakpointBit = 5;
    localparam int CsrReq_HaltBit       = 6;
    localparam int CsrReq_ResumeBit     = 7;
    localparam int CsrReq_WfiBit        = 8;
    localparam int CsrReq_FenceBit      = 9;
    localparam int CsrReq_TotalBits     = 10;

endpackage

// File: rtl/csr_req_arbiter.sv
// rtl/csr_req_arbiter.sv - two-master round-robin arbiter in front of the CSR unit
module csr_req_arbiter
    import river_cfg_pkg::*;
    import csr_pkg::*;
#(
    parameter int timeout_cycles = 64,
    parameter int cnt_width      = 8
) (
    input  logic                        i_clk,
    input  logic                        i_nrst,
    input  logic                        i_e_req_valid,
    output logic                        o_e_req_ready,
    input  logic [CsrReq_TotalBits-1:0] i_e_req_type,
    input  logic [11:0]                 i_e_req_addr,
    input  logic [RISCV_ARCH-1:0]       i_e_req_data,
    output logic                        o_e_resp_valid,
    input  logic                        i_e_resp_ready,
    output logic [RISCV_ARCH-1:0]       o_e_resp_data,
    output logic                        o_e_resp_exception,
    input  logic                        i_d_req_valid,
    output logic                        o_d_req_ready,
    input  logic [CsrReq_TotalBits-1:0] i_d_req_type,
    input  logic [11:0]                 i_d_req_addr,
    input  logic [RISCV_ARCH-1:0]       i_d_req_data,
    output logic                        o_d_resp_valid,
    input  logic                        i_d_resp_ready,
    output logic [RISCV_ARCH-1:0]       o_d_resp_data,
    output logic                        o_d_resp_exception,
    output logic                        o_req_valid,
    input  logic                        i_req_ready,
    output logic [CsrReq_TotalBits-1:0] o_req_type,
    output logic [11:0]                 o_req_addr,
    output logic [RISCV_ARCH-1:0]       o_req_data,
    input  logic                        i_resp_valid,
    output logic                        o_resp_ready,
    input  logic [RISCV_ARCH-1:0]       i_resp_data,
    input  logic                        i_resp_exception,
    output logic                        o_timeout
);

    localparam logic [cnt_width-1:0] TO_LIMIT = cnt_width'(timeout_cycles - 1);

    csr_req_arbiter_registers r, rin;
    logic [cnt_width-1:0]     cnt, cnt_next;
    logic                     winner;
    logic                     grant_ok;
    logic                     owner_ready;
    logic                     timeout_pulse;

    function automatic logic rr_pick(input logic e_valid, input logic d_valid, input logic last);
        if (e_valid && d_valid) return ~last;
        return d_valid ? Owner_D : Owner_E;
    endfunction

    always_comb begin
        rin           = r;
        cnt_next      = cnt;
        timeout_pulse = 1'b0;
        winner        = rr_pick(i_e_req_valid, i_d_req_valid, r.last_grant);
        grant_ok      = i_nrst && (r.state == ArbState_Idle) && !r.drain
                        && (i_e_req_valid || i_d_req_valid);
        owner_ready   = (r.owner == Owner_D) ? i_d_resp_ready : i_e_resp_ready;

        case (r.state)
            ArbState_Idle: begin
                if (grant_ok) begin
                    rin.owner      = winner;
                    rin.last_grant = winner;
                    rin.req_type   = (winner == Owner_D) ? i_d_req_type : i_e_req_type;
                    rin.req_addr   = (winner == Owner_D) ? i_d_req_addr : i_e_req_addr;
                    rin.req_data   = (winner == Owner_D) ? i_d_req_data : i_e_req_data;
                    rin.state      = ArbState_Req;
                end
            end
            ArbState_Req: begin
                if (i_req_ready) begin
                    rin.state = ArbState_Resp;
                    cnt_next  = '0;
                end
            end
            ArbState_Resp: begin
                // A response arriving on the limit cycle still beats the timeout
                if (i_resp_valid) begin
                    rin.resp_data      = i_resp_data;
                    rin.resp_exception = i_resp_exception;
                    rin.state          = ArbState_Out;
                end else if (timeout_cycles != 0 && cnt == TO_LIMIT) begin
                    rin.resp_data      = '0;
                    rin.resp_exception = 1'b1;
                    rin.drain          = 1'b1;
                    rin.state          = ArbState_Out;
                    timeout_pulse      = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ArbState_Out: begin
                if (owner_ready) begin
                    rin.state = ArbState_Idle;
                end
            end
            default: rin.state = ArbState_Idle;
        endcase

        // The late response of a timed-out transaction is swallowed here
        if (r.drain && r.state != ArbState_Req && i_resp_valid) begin
            rin.drain = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r   <= csr_req_arbiter_r_reset;
            cnt <= '0;
        end else begin
            r   <= rin;
            cnt <= cnt_next;
        end
    end

    assign o_e_req_ready      = grant_ok && (winner == Owner_E);
    assign o_d_req_ready      = grant_ok && (winner == Owner_D);
    assign o_req_valid        = (r.state == ArbState_Req);
    assign o_req_type         = r.req_type;
    assign o_req_addr         = r.req_addr;
    assign o_req_data         = r.req_data;
    assign o_resp_ready       = (r.state == ArbState_Resp) || (r.drain && r.state != ArbState_Req);
    assign o_e_resp_valid     = (r.state == ArbState_Out) && (r.owner == Owner_E);
    assign o_d_resp_valid     = (r.state == ArbState_Out) && (r.owner == Owner_D);
    assign o_e_resp_data      = r.resp_data;
    assign o_d_resp_data      = r.resp_data;
    assign o_e_resp_exception = r.resp_exception;
    assign o_d_resp_exception = r.resp_exception;
    assign o_timeout          = timeout_pulse;

endmodule

// File: tb/tb_csr_req_arbiter.sv
// tb/tb_csr_req_arbiter.sv - scoreboard bench for csr_req_arbiter
module tb_csr_req_arbiter;

    import river_cfg_pkg::*;

    typedef struct {
        logic                  owner;
        logic [RISCV_ARCH-1:0] data;
        logic                  exc;
    } exp_t;

    logic                        clk;
    logic                        rst_n;
    logic                        e_req_valid, d_req_valid;
    logic                        o_e_req_ready, o_d_req_ready;
    logic [CsrReq_TotalBits-1:0] e_req_type, d_req_type;
    logic [11:0]                 e_req_addr, d_req_addr;
    logic [RISCV_ARCH-1:0]       e_req_data, d_req_data;
    logic                        o_e_resp_valid, o_d_resp_valid;
    logic                        e_resp_ready, d_resp_ready;
    logic [RISCV_ARCH-1:0]       o_e_resp_data, o_d_resp_data;
    logic                        o_e_resp_exception, o_d_resp_exception;
    logic                        o_req_valid;
    logic                        req_ready;
    logic [CsrReq_TotalBits-1:0] o_req_type;
    logic [11:0]                 o_req_addr;
    logic [RISCV_ARCH-1:0]       o_req_data;
    logic                        resp_valid;
    logic                        o_resp_ready;
    logic [RISCV_ARCH-1:0]       resp_data;
    logic                        resp_exception;
    logic                        o_timeout;

    int   n_checks   = 0;
    int   n_fail     = 0;
    int   e_resp_cnt = 0;
    int   d_resp_cnt = 0;
    exp_t exp_q[$];
    logic [11:0] req_q[$];

    csr_req_arbiter #(.timeout_cycles(4), .cnt_width(8)) dut (
        .i_clk(clk), .i_nrst(rst_n),
        .i_e_req_valid(e_req_valid), .o_e_req_ready(o_e_req_ready),
        .i_e_req_type(e_req_type), .i_e_req_addr(e_req_addr), .i_e_req_data(e_req_data),
        .o_e_resp_valid(o_e_resp_valid), .i_e_resp_ready(e_resp_ready),
        .o_e_resp_data(o_e_resp_data), .o_e_resp_exception(o_e_resp_exception),
        .i_d_req_valid(d_req_valid), .o_d_req_ready(o_d_req_ready),
        .i_d_req_type(d_req_type), .i_d_req_addr(d_req_addr), .i_d_req_data(d_req_data),
        .o_d_resp_valid(o_d_resp_valid), .i_d_resp_ready(d_resp_ready),
        .o_d_resp_data(o_d_resp_data), .o_d_resp_exception(o_d_resp_exception),
        .o_req_valid(o_req_valid), .i_req_ready(req_ready),
        .o_req_type(o_req_type), .o_req_addr(o_req_addr), .o_req_data(o_req_data),
        .i_resp_valid(resp_valid), .o_resp_ready(o_resp_ready),
        .i_resp_data(resp_data), .i_resp_exception(resp_exception),
        .o_timeout(o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal;
    end

    // Scores CSR-side accepts and master-side responses at the falling edge
    task automatic tick();
        exp_t                  x;
        logic [11:0]           a;
        logic [RISCV_ARCH-1:0] got_d;
        logic                  got_x;
        logic [1:0]            rv;
        @(negedge clk);
        if (rst_n) begin
            n_checks++;
            if (o_e_resp_valid && o_d_resp_valid) begin
                n_fail++;
                $display("FAIL resp_exclusive: e_valid=1 d_valid=1, required at most one");
            end
            if (o_req_valid && req_ready) begin
                n_checks++;
                if (req_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL req_order: got addr %h, required no request", o_req_addr);
                end else begin
                    a = req_q.pop_front();
                    if (o_req_addr !== a) begin
                        n_fail++;
                        $display("FAIL req_order: got addr %h, required %h", o_req_addr, a);
                    end
                end
            end
            rv = {o_d_resp_valid && d_resp_ready, o_e_resp_valid && e_resp_ready};
            for (int p = 0; p < 2; p++) begin
                if (rv[p]) begin
                    n_checks++;
                    if (p == 0) e_resp_cnt++; else d_resp_cnt++;
                    got_d = (p == 0) ? o_e_resp_data : o_d_resp_data;
                    got_x = (p == 0) ? o_e_resp_exception : o_d_resp_exception;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL resp_unexpected: port %0d data %h exc %0b, required none", p, got_d, got_x);
                    end else begin
                        x = exp_q.pop_front();
                        if (x.owner !== (p == 1) || got_d !== x.data || got_x !== x.exc) begin
                            n_fail++;
                            $display("FAIL resp_score: port %0d data %h exc %0b, required port %0d data %h exc %0b",
                                     p, got_d, got_x, x.owner, x.data, x.exc);
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic owner, input logic [RISCV_ARCH-1:0] data, input logic exc);
        exp_t x;
        x.owner = owner;
        x.data  = data;
        x.exc   = exc;
        exp_q.push_back(x);
    endtask

    task automatic wait_grant(input logic port);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if ((port ? o_d_req_ready : o_e_req_ready) === 1'b1) begin
                ok = 1'b1;
                tick();
                if (port) d_req_valid = 1'b0; else e_req_valid = 1'b0;
            end else begin
                tick();
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL grant_wait: port %0d not granted in 40 cycles, required grant", port);
        end
    endtask

    task automatic csr_serve(input int req_delay, input int resp_delay,
                             input logic [RISCV_ARCH-1:0] data, input logic exc);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (o_req_valid === 1'b1) ok = 1'b1; else tick();
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL csr_req_wait: o_req_valid=0 after 20 cycles, required 1");
        end
        repeat (req_delay) tick();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        repeat (resp_delay) tick();
        resp_valid     = 1'b1;
        resp_data      = data;
        resp_exception = exc;
        tick();
        resp_valid     = 1'b0;
        resp_data      = '0;
        resp_exception = 1'b0;
    endtask

    task automatic wait_done(input int e_t, input int d_t);
        for (int i = 0; i < 40 && !(e_resp_cnt >= e_t && d_resp_cnt >= d_t); i++) tick();
        n_checks++;
        if (e_resp_cnt != e_t || d_resp_cnt != d_t) begin
            n_fail++;
            $display("FAIL resp_count: e=%0d d=%0d, required e=%0d d=%0d", e_resp_cnt, d_resp_cnt, e_t, d_t);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({o_req_valid, o_e_req_ready, o_d_req_ready, o_resp_ready, o_e_resp_valid,
             o_d_resp_valid, o_timeout, o_e_resp_exception, o_d_resp_exception} !== 9'b0 ||
            o_req_type !== '0 || o_req_addr !== '0 || o_req_data !== '0 ||
            o_e_resp_data !== '0 || o_d_resp_data !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: req_valid=%0b resp_ready=%0b addr=%h resp_data=%h, required all 0",
                     o_req_valid, o_resp_ready, o_req_addr, o_e_resp_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_e_only_read();
        int d0;
        d0 = d_resp_cnt;
        e_req_valid = 1'b1;
        e_req_type  = 10'h001;
        e_req_addr  = 12'h300;
        e_req_data  = '0;
        req_q.push_back(12'h300);
        push_exp(1'b0, 64'h8, 1'b0);
        #1;
        n_checks++;
        if (o_e_req_ready !== 1'b1 || o_d_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL e_only_ready: e=%0b d=%0b, required e=1 d=0", o_e_req_ready, o_d_req_ready);
        end
        wait_grant(1'b0);
        csr_serve(0, 1, 64'h8, 1'b0);
        wait_done(e_resp_cnt + 1, d0);
    endtask

    task automatic test_round_robin();
        int e0, d0;
        do_reset();
        e0 = e_resp_cnt;
        d0 = d_resp_cnt;
        e_req_valid = 1'b1; e_req_type = 10'h002; e_req_addr = 12'h341; e_req_data = 64'h1111;
        d_req_valid = 1'b1; d_req_type = 10'h001; d_req_addr = 12'h7b0; d_req_data = '0;
        req_q.push_back(12'h341);
        req_q.push_back(12'h7b0);
        req_q.push_back(12'h342);
        push_exp(1'b0, 64'hA0, 1'b0);
        push_exp(1'b1, 64'hB0, 1'b1);
        push_exp(1'b0, 64'hC0, 1'b0);
        #1;
        n_checks++;
        if (o_e_req_ready !== 1'b1 || o_d_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_first_tie: e=%0b d=%0b, required e=1 d=0", o_e_req_ready, o_d_req_ready);
        end
        wait_grant(1'b0);
        // e re-requests so the next Idle sees a tie that d must win
        e_req_valid = 1'b1; e_req_addr = 12'h342; e_req_data = 64'h2222;
        csr_serve(0, 1, 64'hA0, 1'b0);
        wait_grant(1'b1);
        csr_serve(0, 2, 64'hB0, 1'b1);
        wait_grant(1'b0);
        csr_serve(0, 0, 64'hC0, 1'b0);
        wait_done(e0 + 2, d0 + 1);
    endtask

    task automatic test_backpressure_timeout();
        int e0, d0;
        e0 = e_resp_cnt;
        d0 = d_resp_cnt;
        e_req_valid = 1'b1; e_req_type = 10'h002; e_req_addr = 12'h305;
        e_req_data  = 64'hCAFE_0000_1234_5678;
        req_q.push_back(12'h305);
        push_exp(1'b0, 64'h0, 1'b1);
        wait_grant(1'b0);
        for (int k = 0; k < 6; k++) begin
            #1;
            n_checks++;
            if (o_req_valid !== 1'b1 || o_req_type !== 10'h002 || o_req_addr !== 12'h305 ||
                o_req_data !== 64'hCAFE_0000_1234_5678) begin
                n_fail++;
                $display("FAIL req_stable: cycle %0d valid=%0b type=%h addr=%h data=%h, required 1 002 305 cafe000012345678",
                         k, o_req_valid, o_req_type, o_req_addr, o_req_data);
            end
            if (k == 5) req_ready = 1'b1;
            tick();
        end
        req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (o_timeout !== (k == 3)) begin
                n_fail++;
                $display("FAIL timeout_cycle: resp cycle %0d o_timeout=%0b, required %0b", k, o_timeout, (k == 3));
            end
            tick();
        end
        #1;
        n_checks++;
        if (o_timeout !== 1'b0 || o_e_resp_valid !== 1'b1 || o_d_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_out: timeout=%0b e_valid=%0b d_valid=%0b, required 0 1 0",
                     o_timeout, o_e_resp_valid, o_d_resp_valid);
        end
        wait_done(e0 + 1, d0);
    endtask

    task automatic test_late_response();
        int e0, d0;
        e0 = e_resp_cnt;
        d0 = d_resp_cnt;
        d_req_valid = 1'b1; d_req_type = 10'h001; d_req_addr = 12'h7b1; d_req_data = '0;
        for (int k = 0; k < 10; k++) begin
            #1;
            n_checks++;
            if (o_d_req_ready !== 1'b0 || o_resp_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_hold: cycle %0d d_ready=%0b resp_ready=%0b, required 0 1",
                         k, o_d_req_ready, o_resp_ready);
            end
            tick();
        end
        resp_valid = 1'b1; resp_data = 64'hDEAD; resp_exception = 1'b1;
        #1;
        n_checks++;
        if (o_d_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_late_cycle: d_ready=%0b, required 0", o_d_req_ready);
        end
        tick();
        resp_valid = 1'b0; resp_data = '0; resp_exception = 1'b0;
        #1;
        n_checks++;
        if (o_d_req_ready !== 1'b1 || o_resp_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_clear: d_ready=%0b resp_ready=%0b, required 1 0", o_d_req_ready, o_resp_ready);
        end
        req_q.push_back(12'h7b1);
        push_exp(1'b1, 64'h55, 1'b0);
        wait_grant(1'b1);
        csr_serve(0, 0, 64'h55, 1'b0);
        wait_done(e0, d0 + 1);
    endtask

    task automatic test_reset_mid_resp();
        int e0, d0;
        e0 = e_resp_cnt;
        d0 = d_resp_cnt;
        e_req_valid = 1'b1; e_req_type = 10'h001; e_req_addr = 12'h301; e_req_data = '0;
        req_q.push_back(12'h301);
        wait_grant(1'b0);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        e_req_valid = 1'b1; e_req_addr = 12'h302; e_req_data = 64'h77;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_req_valid, o_e_req_ready, o_d_req_ready, o_resp_ready, o_e_resp_valid,
             o_d_resp_valid, o_timeout} !== 7'b0 || o_req_addr !== '0 || o_req_data !== '0) begin
            n_fail++;
            $display("FAIL reset_async: req_valid=%0b e_ready=%0b resp_ready=%0b addr=%h, required all 0",
                     o_req_valid, o_e_req_ready, o_resp_ready, o_req_addr);
        end
        tick();
        tick();
        rst_n = 1'b1;
        req_q.push_back(12'h302);
        push_exp(1'b0, 64'h1234, 1'b0);
        wait_grant(1'b0);
        csr_serve(0, 1, 64'h1234, 1'b0);
        wait_done(e0 + 1, d0);
    endtask

    initial begin
        rst_n = 1'b0;
        e_req_valid = 1'b0; e_req_type = '0; e_req_addr = '0; e_req_data = '0; e_resp_ready = 1'b1;
        d_req_valid = 1'b0; d_req_type = '0; d_req_addr = '0; d_req_data = '0; d_resp_ready = 1'b1;
        req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0; resp_exception = 1'b0;

        test_reset();
        test_e_only_read();
        test_round_robin();
        test_backpressure_timeout();
        test_late_response();
        test_reset_mid_resp();

        n_checks++;
        if (exp_q.size() != 0 || req_q.size() != 0) begin
            n_fail++;
            $display("FAIL queues_drained: exp=%0d req=%0d left, required 0 0", exp_q.size(), req_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_req_arbiter.md
Name: csr_req_arbiter

Overview:
- Sits directly upstream of the CSR unit in the River core.
- Arbitrates CSR requests from two masters onto the single CSR request/response channel: the executor (port e) and the debug port / progbuf engine (port d).
- Keeps one transaction outstanding, routes the response back to the owner, and turns a missing CSR response into an exception after a programmable timeout.

Parameters:
- timeout_cycles, default 64: cycles allowed between CSR request accept and response. 0 disables the timeout.
- cnt_width, default 8: width of the timeout counter. timeout_cycles must be below 2^cnt_width.

Ports:
- i_clk  in  1  core clock
- i_nrst  in  1  reset, asynchronous, active-low
- i_e_req_valid  in  1  executor request valid
- o_e_req_ready  out  1  executor request accepted
- i_e_req_type  in  CsrReq_TotalBits  one-hot CSR request type (river_cfg_pkg encoding)
- i_e_req_addr  in  12  CSR address
- i_e_req_data  in  RISCV_ARCH  write data / trap value
- o_e_resp_valid  out  1  response to executor valid
- i_e_resp_ready  in  1  executor takes response
- o_e_resp_data  out  RISCV_ARCH  read data
- o_e_resp_exception  out  1  access fault or timeout
- i_d_req_valid, o_d_req_ready, i_d_req_type, i_d_req_addr, i_d_req_data, o_d_resp_valid, i_d_resp_ready, o_d_resp_data, o_d_resp_exception: same as the e-port, for the debug master
- o_req_valid  out  1  request to CSR
- i_req_ready  in  1  CSR accepted request
- o_req_type  out  CsrReq_TotalBits
- o_req_addr  out  12
- o_req_data  out  RISCV_ARCH
- i_resp_valid  in  1  CSR response valid
- o_resp_ready  out  1  arbiter takes CSR response
- i_resp_data  in  RISCV_ARCH
- i_resp_exception  in  1
- o_timeout  out  1  one-cycle pulse when a timeout fires

Behaviour:
- Clock and reset: single clock i_clk. i_nrst is asynchronous, active-low.
- Reset values: state=Idle, last_grant=d (so e wins the first tie), drain=0, counter=0, latched type/addr/data/resp=0. All outputs are 0.
- Idle state:
  - ready is combinational: o_x_req_ready=1 only for the arbitration winner, and only when drain=0.
  - Winner: the single valid requester. If both are valid, the port opposite to last_grant (round-robin).
  - On handshake: latch type/addr/data and owner, set last_grant=owner, go to Req.
- Req state:
  - o_req_valid=1 with registered fields, so it first appears the cycle after acceptance.
  - Fields stay stable until i_req_ready.
  - On i_req_ready: go to Resp and clear the counter.
- Resp state:
  - o_resp_ready=1; the counter increments every cycle.
  - On i_resp_valid: latch data and exception, go to Out. A response in the same cycle as the counter hitting the limit wins; no timeout.
  - Counter reaches timeout_cycles-1 (timeout_cycles≠0) with no response: data=0, exception=1, pulse o_timeout, set drain=1, go to Out.
- Out state:
  - Owner's o_x_resp_valid=1 with the latched data/exception. The other port's resp_valid=0.
  - On the owner's ready: go to Idle.
- Drain:
  - While drain=1, o_resp_ready=1 in every state except Req.
  - The first i_resp_valid is acknowledged and discarded, then drain clears.
  - No new request is granted while drain=1.
- Minimum round trip (i_req_ready and i_resp_valid both immediate, owner ready): accept at N, o_req_valid at N+1, Resp at N+2, Out at N+3, Idle at N+4 (next grant at N+4).
- Requester withdrawing valid before grant: permitted, no side effect. Once accepted, a transaction cannot be aborted.
- Reset asserted mid-transaction: immediate return to reset values. Any outstanding CSR response is lost; the CSR unit is reset by the same i_nrst.

Decomposition:
- csr_pkg gains:
  - state constants ArbState_Idle=0, ArbState_Req=1, ArbState_Resp=2, ArbState_Out=3
  - owner constants Owner_E=0, Owner_D=1
  - register struct csr_req_arbiter_registers
- Request type encoding and RISCV_ARCH come from river_cfg_pkg.
- No sub-module: the round-robin pick is a two-line combinational function inside the block.

Test Plan:
- e-only read: e req addr=12'h300, CSR responds 64'h8 two cycles after accept → e resp data=64'h8, exception=0; d resp_valid stays 0.
- Simultaneous requests twice after reset: e and d both valid → first grant e, second grant d; o_req_addr order 12'h341 then 12'h7b0.
- CSR backpressure: i_req_ready low for 5 cycles → o_req_valid/type/addr/data stable for 6 cycles, counter stays 0 until accept.
- Timeout: timeout_cycles=4, no response → o_timeout pulses 4 cycles after accept; owner gets data=0, exception=1.
- Late response after timeout: i_resp_valid 10 cycles later → acknowledged and discarded, owner sees no second response; a pending d request is granted only after drain clears.
- Reset mid-Resp: i_nrst low asynchronously → all outputs 0 within the same cycle; after release the first accepted request completes normally.
